// File: rtl/pfb_frame_sched_pkg.sv
// Shared types and defaults for the PFB frame scheduler.
//   sched_state_t : scheduler FSM states
//   sample_t      : one sample at the default width
//   HOLD_LEN      : idle cycles per frame at the default FFT_LEN/DEC_FAC
//   BEAT_W        : beat/hold counter width at the default FFT_LEN
//   clog2_min1()  : $clog2 clamped to at least 1 bit
package pfb_pkg;
    typedef enum logic [1:0] {IDLE, FILL, READ, HOLD} sched_state_t;

    localparam int WIDTH_DEF   = 16;
    localparam int FFT_LEN_DEF = 32;
    localparam int DEC_FAC_DEF = 24;
    localparam int HOLD_LEN    = FFT_LEN_DEF - DEC_FAC_DEF;
    localparam int BEAT_W      = $clog2(FFT_LEN_DEF);

    typedef logic [WIDTH_DEF-1:0] sample_t;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/pfb_frame_sched_if.sv
// Bus bundle between the scheduler, the upstream ADC->DSP FIFO read side and
// the PFB front end.
//   s_axis_tdata/tvalid/tready : FIFO read port (tready is the read strobe)
//   rd_data_count              : FIFO read-side occupancy
//   fifo_prog_full             : FIFO programmable-full flag
//   m_axis_tdata/tvalid        : samples to the PFB (no backpressure)
//   m_axis_tuser / m_axis_tlast: first / last sample of a frame
// Modports: master = scheduler side, slave = environment side.
interface pfb_frame_sched_if
    import pfb_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 128
);
    localparam int CNT_W = clog2_min1(FIFO_DEPTH);

    logic [WIDTH-1:0] s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [CNT_W-1:0] rd_data_count;
    logic             fifo_prog_full;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tuser;
    logic             m_axis_tlast;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, rd_data_count, fifo_prog_full,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, rd_data_count, fifo_prog_full,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
    );
endinterface

// File: rtl/pfb_frame_sched_ctr.sv
// Beat and hold counters for one PFB frame.
//   clk, rst   : clock, synchronous active-high reset
//   beat_inc   : one FIFO handshake this cycle
//   hold_en    : scheduler is in HOLD
//   beat_cnt   : handshakes so far in the current frame (0..DEC_FAC-1)
//   beat_last  : beat_cnt is the last beat of the frame
//   hold_last  : this is the last HOLD cycle
module pfb_frame_ctr #(
    parameter int DEC_FAC  = 24,
    parameter int HOLD_LEN = 8,
    parameter int W        = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         beat_inc,
    input  logic         hold_en,
    output logic [W-1:0] beat_cnt,
    output logic         beat_last,
    output logic         hold_last
);
    logic [W-1:0] beat_cnt_reg;
    logic [W-1:0] hold_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_reg <= '0;
            hold_cnt_reg <= '0;
        end else begin
            // Both counters wrap on their terminal count so every frame
            // starts from zero without an explicit clear.
            if (beat_inc)
                beat_cnt_reg <= beat_last ? '0 : beat_cnt_reg + 1'b1;
            if (hold_en)
                hold_cnt_reg <= hold_last ? '0 : hold_cnt_reg + 1'b1;
        end
    end

    assign beat_cnt  = beat_cnt_reg;
    assign beat_last = (beat_cnt_reg == W'(DEC_FAC - 1));
    // With HOLD_LEN == 0 the HOLD state is never entered, so the
    // all-ones compare value is harmless.
    assign hold_last = (hold_cnt_reg == W'(HOLD_LEN - 1));
endmodule

// File: rtl/pfb_frame_sched.sv
// PFB frame read scheduler (DSP clock domain).
// Pops DEC_FAC samples from the ADC->DSP FIFO every FFT_LEN cycles after an
// initial prefill, tags frame boundaries and flags underflow/overflow.
// Ports:
//   clk, rst   : DSP clock, synchronous active-high reset
//   en         : run enable (a frame in flight always completes)
//   bus        : FIFO read side + PFB output (pfb_frame_sched_if.master)
//   frame_cnt  : completed frames, wraps at 2^32
//   underflow  : sticky, FIFO empty while reading
//   overflow   : sticky, fifo_prog_full seen outside IDLE
//   done       : capture complete (only with PFB_CAPTURE_STOP_EN)
// Build option: define PFB_CAPTURE_STOP_EN to stop after NUM_FRAMES frames
// and park in IDLE until reset.
module pfb_frame_sched
    import pfb_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FFT_LEN    = 32,
    parameter int DEC_FAC    = 24,
    parameter int FIFO_DEPTH = 128,
    parameter int PREFILL    = 48,
    parameter int NUM_FRAMES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    pfb_frame_sched_if.master   bus,
    output logic [31:0]         frame_cnt,
    output logic                underflow,
    output logic                overflow,
    output logic                done
);
    localparam int HOLD_CYC = FFT_LEN - DEC_FAC;
    localparam int BW       = clog2_min1(FFT_LEN);
    localparam int CNT_W    = clog2_min1(FIFO_DEPTH);

`ifdef PFB_CAPTURE_STOP_EN
    localparam bit CAPTURE_EN = 1'b1;
`else
    localparam bit CAPTURE_EN = 1'b0;
`endif

    sched_state_t     state_reg;
    logic             tready_reg;
    logic             primed_reg;
    logic             tvalid_reg;
    logic             tuser_reg;
    logic             tlast_reg;
    logic [WIDTH-1:0] tdata_reg;
    logic [31:0]      frame_cnt_reg;
    logic             underflow_reg;
    logic             overflow_reg;
    logic             done_reg;

    logic [BW-1:0]    beat_cnt;
    logic             beat_last;
    logic             hold_last;
    logic             hs;
    logic             frame_end;
    logic             stop_now;

    assign hs        = tready_reg & bus.s_axis_tvalid;
    assign frame_end = hs & beat_last;
    // frame_cnt updates on the same edge as the final handshake, so the
    // frame now ending is the last one when the count is one short.
    assign stop_now  = CAPTURE_EN && (frame_cnt_reg == 32'(NUM_FRAMES - 1));

    pfb_frame_ctr #(
        .DEC_FAC  (DEC_FAC),
        .HOLD_LEN (HOLD_CYC),
        .W        (BW)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .beat_inc  (hs),
        .hold_en   (state_reg == HOLD),
        .beat_cnt  (beat_cnt),
        .beat_last (beat_last),
        .hold_last (hold_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            tready_reg    <= 1'b0;
            primed_reg    <= 1'b0;
            tvalid_reg    <= 1'b0;
            tuser_reg     <= 1'b0;
            tlast_reg     <= 1'b0;
            tdata_reg     <= '0;
            frame_cnt_reg <= '0;
            underflow_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            tvalid_reg <= hs;
            tuser_reg  <= hs && (beat_cnt == '0);
            tlast_reg  <= frame_end;
            if (hs)
                tdata_reg <= bus.s_axis_tdata;
            if (frame_end)
                frame_cnt_reg <= frame_cnt_reg + 32'd1;
            if (frame_end && stop_now)
                done_reg <= 1'b1;
            if (tready_reg && !bus.s_axis_tvalid)
                underflow_reg <= 1'b1;
            if ((state_reg != IDLE) && bus.fifo_prog_full)
                overflow_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    // Once prefilled, a restart goes straight to READ.
                    if (en && !done_reg) begin
                        if (primed_reg) begin
                            state_reg  <= READ;
                            tready_reg <= 1'b1;
                        end else begin
                            state_reg <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (!en) begin
                        state_reg <= IDLE;
                    end else if (bus.rd_data_count >= CNT_W'(PREFILL)) begin
                        state_reg  <= READ;
                        tready_reg <= 1'b1;
                        primed_reg <= 1'b1;
                    end
                end
                READ: begin
                    if (frame_end) begin
                        if (HOLD_CYC != 0) begin
                            state_reg  <= HOLD;
                            tready_reg <= 1'b0;
                        end else if (!en || stop_now) begin
                            state_reg  <= IDLE;
                            tready_reg <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (hold_last) begin
                        if (en && !done_reg) begin
                            state_reg  <= READ;
                            tready_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    tready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_axis_tready = tready_reg;
    assign bus.m_axis_tdata  = tdata_reg;
    assign bus.m_axis_tvalid = tvalid_reg;
    assign bus.m_axis_tuser  = tuser_reg;
    assign bus.m_axis_tlast  = tlast_reg;
    assign frame_cnt         = frame_cnt_reg;
    assign underflow         = underflow_reg;
    assign overflow          = overflow_reg;
    assign done              = done_reg;
endmodule

// File: tb/tb_pfb_frame_sched.sv
// Directed bench for pfb_frame_sched.
// dut_a: FFT_LEN=32, DEC_FAC=24, fed by a queue-based FIFO model filled at
//        one sample per 12 ns while the DSP clock runs at 9 ns.
// dut_b: FFT_LEN=DEC_FAC=32 (critical sampling), always-valid source.
`timescale 1ns/100ps
module tb_pfb_frame_sched;
    import pfb_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    always #4.5 clk = ~clk;

    pfb_frame_sched_if #(.WIDTH(W), .FIFO_DEPTH(128)) bus_a ();
    pfb_frame_sched_if #(.WIDTH(W), .FIFO_DEPTH(128)) bus_b ();

    logic [31:0] fc_a, fc_b;
    logic        uf_a, of_a, done_a, uf_b, of_b, done_b;

    pfb_frame_sched #(
        .WIDTH(W), .FFT_LEN(32), .DEC_FAC(24), .FIFO_DEPTH(128),
        .PREFILL(48), .NUM_FRAMES(4)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .bus(bus_a),
        .frame_cnt(fc_a), .underflow(uf_a), .overflow(of_a), .done(done_a)
    );

    pfb_frame_sched #(
        .WIDTH(W), .FFT_LEN(32), .DEC_FAC(32), .FIFO_DEPTH(128),
        .PREFILL(48), .NUM_FRAMES(4)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .bus(bus_b),
        .frame_cnt(fc_b), .underflow(uf_b), .overflow(of_b), .done(done_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- FIFO model for dut_a ----------------
    sample_t fifo_q[$];
    sample_t adc_next   = '0;
    bit      adc_on     = 1'b0;
    int      stall_left = 0;

    // ADC writes at 1 + 12k ns, never coinciding with DSP clock edges.
    initial begin
        #1;
        forever begin
            if (adc_on) begin
                fifo_q.push_back(adc_next);
                adc_next = adc_next + 1'b1;
            end
            #12;
        end
    end

    always @(negedge clk) begin
        bus_a.s_axis_tdata = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        if (stall_left > 0) begin
            bus_a.s_axis_tvalid = 1'b0;
            stall_left--;
        end else begin
            bus_a.s_axis_tvalid = (fifo_q.size() > 0);
        end
        bus_a.rd_data_count = (fifo_q.size() > 127) ? 7'd127 : 7'(fifo_q.size());
    end

    always @(posedge clk)
        if (bus_a.s_axis_tready && bus_a.s_axis_tvalid)
            void'(fifo_q.pop_front());

    // ---------------- source for dut_b ----------------
    logic [W-1:0] b_next = '0;
    always @(negedge clk) bus_b.s_axis_tdata = b_next;
    always @(posedge clk)
        if (bus_b.s_axis_tready && bus_b.s_axis_tvalid)
            b_next <= b_next + 1'b1;

    // ---------------- output monitor for dut_a ----------------
    int      cyc      = 0;
    bit      mon_on   = 1'b0;
    sample_t exp_data = '0;
    int      beat_idx = 0;
    int      sof_t[$];
    int      eof_t[$];

    always @(negedge clk) begin
        cyc++;
        if (mon_on && bus_a.m_axis_tvalid) begin
            check("a_data", bus_a.m_axis_tdata, exp_data);
            check("a_tuser", bus_a.m_axis_tuser, 32'(beat_idx == 0));
            check("a_tlast", bus_a.m_axis_tlast, 32'(beat_idx == 23));
            if (bus_a.m_axis_tuser) sof_t.push_back(cyc);
            if (bus_a.m_axis_tlast) begin
                eof_t.push_back(cyc);
                $display("A frame end: last data=%0d frame_cnt=%0d", bus_a.m_axis_tdata, fc_a);
            end
            exp_data = exp_data + 1'b1;
            beat_idx = (beat_idx == 23) ? 0 : beat_idx + 1;
        end
    end

    // Wait for the next tuser (want_last=0) or tlast (want_last=1) on dut_a.
    task automatic wait_a(input string tag, input bit want_last);
        int  n = 0;
        bit  found = 1'b0;
        do begin
            tick();
            n++;
            found = want_last ? bus_a.m_axis_tlast : bus_a.m_axis_tuser;
        end while (!found && n < 100);
        check(tag, 32'(found), 1);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_tvalid"}, bus_a.m_axis_tvalid, 0);
        check({tag, "_tuser"},  bus_a.m_axis_tuser, 0);
        check({tag, "_tlast"},  bus_a.m_axis_tlast, 0);
        check({tag, "_tdata"},  bus_a.m_axis_tdata, 0);
        check({tag, "_tready"}, bus_a.s_axis_tready, 0);
        check({tag, "_fcnt"},   fc_a, 0);
        check({tag, "_uflow"},  uf_a, 0);
        check({tag, "_oflow"},  of_a, 0);
        check({tag, "_done"},   done_a, 0);
    endtask

    initial begin
        int t0, fc0, busy, n;
        bit seen;
        bus_a.s_axis_tvalid  = 1'b0;
        bus_a.s_axis_tdata   = '0;
        bus_a.rd_data_count  = '0;
        bus_a.fifo_prog_full = 1'b0;
        bus_b.s_axis_tvalid  = 1'b1;
        bus_b.s_axis_tdata   = '0;
        bus_b.rd_data_count  = 7'd127;
        bus_b.fifo_prog_full = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        check_a_zero("rst");
        check("rst_b_tready", bus_b.s_axis_tready, 0);
        rst = 1'b0;
        tick();
        $display("reset released");

        // ---- critical sampling: DEC_FAC == FFT_LEN ----
        en_b = 1'b1;
        n = 0;
        while (!bus_b.m_axis_tvalid && n < 20) begin tick(); n++; end
        check("b_start", bus_b.m_axis_tvalid, 1);
        for (int k = 0; k < 96; k++) begin
            check("b_tready", bus_b.s_axis_tready, 1);
            check("b_tvalid", bus_b.m_axis_tvalid, 1);
            check("b_tdata",  bus_b.m_axis_tdata, 32'(k));
            check("b_tuser",  bus_b.m_axis_tuser, 32'(k % 32 == 0));
            check("b_tlast",  bus_b.m_axis_tlast, 32'(k % 32 == 31));
            if (k % 32 == 31) $display("B frame end: data=%0d frame_cnt=%0d", bus_b.m_axis_tdata, fc_b);
            tick();
        end
        check("b_fcnt", fc_b, 3);
`ifdef PFB_CAPTURE_STOP_EN
        repeat (31) tick();
        check("b_last_tlast", bus_b.m_axis_tlast, 1);
        check("b_done", done_b, 1);
        check("b_fcnt4", fc_b, 4);
        busy = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            busy += bus_b.s_axis_tready;
        end
        check("b_parked", 32'(busy), 0);
`else
        check("b_done", done_b, 0);
`endif
        en_b = 1'b0;

`ifndef PFB_CAPTURE_STOP_EN
        // ---- prefill ----
        for (int i = 0; i < 46; i++) fifo_q.push_back(sample_t'(i));
        adc_next = 16'd46;
        mon_on = 1'b1;
        en_a = 1'b1;
        repeat (5) tick();
        check("fill_wait_tready", bus_a.s_axis_tready, 0);
        adc_on = 1'b1;
        n = 0;
        while (bus_a.rd_data_count < 7'd48 && n < 50) begin tick(); n++; end
        check("fill_level", 32'(bus_a.rd_data_count >= 7'd48), 1);
        check("fill_hold_tready", bus_a.s_axis_tready, 0);
        tick();
        check("fill_release_tready", bus_a.s_axis_tready, 1);

        // ---- steady state: 100 frames ----
        n = 0;
        while (fc_a < 100 && n < 4000) begin tick(); n++; end
        check("ss_fcnt", fc_a, 100);
        check("ss_sof_count", 32'(sof_t.size()), 100);
        check("ss_eof_count", 32'(eof_t.size()), 100);
        for (int i = 0; i < 99 && i + 1 < sof_t.size(); i++)
            check("ss_period", 32'(sof_t[i+1] - sof_t[i]), 32);
        for (int i = 0; i < 100 && i < sof_t.size() && i < eof_t.size(); i++)
            check("ss_span", 32'(eof_t[i] - sof_t[i]), 23);
        check("ss_uflow", uf_a, 0);
        check("ss_oflow", of_a, 0);
        check("ss_done", done_a, 0);

        // ---- underflow: 3 stall cycles at beat 10 ----
        wait_a("uf_sof_seen", 1'b0);
        t0 = cyc;
        repeat (8) tick();
        stall_left = 3;
        wait_a("uf_next_sof_seen", 1'b0);
        check("uf_period", 32'(cyc - t0), 35);
        check("uf_flag", uf_a, 1);
        check("uf_oflow", of_a, 0);

        // ---- overflow: prog_full pulse during HOLD ----
        wait_a("of_tlast_seen", 1'b1);
        check("of_before", of_a, 0);
        bus_a.fifo_prog_full = 1'b1;
        tick();
        bus_a.fifo_prog_full = 1'b0;
        tick();
        check("of_flag", of_a, 1);

        // ---- en dropped at beat 5 ----
        wait_a("en_sof_seen", 1'b0);
        fc0 = fc_a;
        repeat (5) tick();
        en_a = 1'b0;
        wait_a("en_tlast_seen", 1'b1);
        check("en_fcnt", fc_a, 32'(fc0 + 1));
        repeat (8) tick();
        busy = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            busy += bus_a.s_axis_tready + bus_a.m_axis_tvalid;
        end
        check("en_idle_activity", 32'(busy), 0);
        check("en_idle_fcnt", fc_a, 32'(fc0 + 1));
        en_a = 1'b1;
        tick();
        check("en_restart_tready", bus_a.s_axis_tready, 1);

        // ---- reset at beat 12 ----
        wait_a("rst_sof_seen", 1'b0);
        repeat (11) tick();
        rst = 1'b1;
        mon_on = 1'b0;
        tick();
        check_a_zero("midrst");
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen |= bus_a.s_axis_tready;
        end
        check("midrst_tready_held", 32'(seen), 0);
        rst = 1'b0;
        en_a = 1'b0;
        adc_on = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
